cpu_sequencer: RTL and testbench

Control unit for the model computer. Owns the program counter (PC) and instruction register. Fetches 8-bit instructions and immediate bytes from the combinational program ROM, then hands operations to the ALU/register-file datapath with a start/done handshake. Issues the register write enables, and stops on HALT, an illegal encoding or an ALU timeout.

---
 rtl/cpu_isa_pkg.sv | 48 ++++
 rtl/cpu_seq_decode.sv | 32 +++
 rtl/cpu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the model computer sequencer.
// Provides field widths, opcode and register codes, the instruction
// word layout and the sequencer state encoding.
package cpu_isa_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned REG_W  = 2;

    // Opcodes, instruction bits [7:4]
    localparam logic [OPC_W-1:0] OP_MOV  = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd3;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd4;
    localparam logic [OPC_W-1:0] OP_DIV  = 4'd5;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd6;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd8;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd9;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'd10;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'd11;

    // Register codes for dst/src fields; code 3 is illegal
    localparam logic [REG_W-1:0] REG_IMM = 2'd0;
    localparam logic [REG_W-1:0] REG_AX  = 2'd1;
    localparam logic [REG_W-1:0] REG_DX  = 2'd2;

    // Instruction word layout
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_IMM   = 3'd2,
        S_EXEC  = 3'd3,
        S_WAIT  = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6,
        S_ERR   = 3'd7
    } state_e;

endpackage

// File: rtl/cpu_seq_decode.sv
// Instruction classifier used during FETCH.
// Ports:
//   instr     - 8-bit instruction word
//   needs_imm - instruction is followed by an immediate byte
//   illegal   - encoding is not executable
//   is_halt   - HALT opcode (takes priority over illegal)
//   wide_wb   - result writes both AX and DX (MUL/DIV)
module cpu_seq_decode
    import cpu_isa_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic              needs_imm,
    output logic              illegal,
    output logic              is_halt,
    output logic              wide_wb
);

    instr_t w;
    assign w = instr_t'(instr);

    always_comb begin
        is_halt   = (w.opcode == OP_HALT);
        wide_wb   = (w.opcode == OP_MUL) || (w.opcode == OP_DIV);
        // Only MUL/DIV may name the immediate as their A operand
        illegal   = (w.opcode > OP_SHR)
                 || (w.dst == 2'd3) || (w.src == 2'd3)
                 || ((w.dst == REG_IMM) && !wide_wb);
        // NOT is unary, so src=0 does not pull in an immediate for it
        needs_imm = wide_wb || ((w.src == REG_IMM) && (w.opcode != OP_NOT));
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Control unit for the model computer: owns PC and IR, fetches
// instructions and immediates from the program ROM, launches the ALU
// with a start/done handshake and issues register write enables.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   run               - start from IDLE, restart from HALT/ERR
//   rom_addr/rom_data - program ROM interface (combinational read)
//   alu_op, dst_sel, src_sel, imm - operation fields to the datapath
//   alu_start/alu_done - ALU handshake
//   wr_ax, wr_dx      - register file write enables
//   halted, error, busy - status
module cpu_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int unsigned       ALU_TIMEOUT = 64,
    parameter logic [ADDR_W-1:0] PC_RESET    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [OPC_W-1:0]  alu_op,
    output logic [REG_W-1:0]  dst_sel,
    output logic [REG_W-1:0]  src_sel,
    output logic [DATA_W-1:0] imm,
    output logic              alu_start,
    input  logic              alu_done,
    output logic              wr_ax,
    output logic              wr_dx,
    output logic              halted,
    output logic              error,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);
    // Counter value on the last tolerated WAIT cycle; ERR then shows up
    // exactly ALU_TIMEOUT cycles after the alu_start pulse.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              wide_q, wide_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic alu_start_d, wr_ax_d, wr_dx_d, halted_d, error_d, busy_d;
    logic dec_needs_imm, dec_illegal, dec_is_halt, dec_wide;

    cpu_seq_decode u_decode (
        .instr     (rom_data),
        .needs_imm (dec_needs_imm),
        .illegal   (dec_illegal),
        .is_halt   (dec_is_halt),
        .wide_wb   (dec_wide)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            imm_q     <= '0;
            wide_q    <= 1'b0;
            cnt_q     <= '0;
            alu_start <= 1'b0;
            wr_ax     <= 1'b0;
            wr_dx     <= 1'b0;
            halted    <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            wide_q    <= wide_d;
            cnt_q     <= cnt_d;
            alu_start <= alu_start_d;
            wr_ax     <= wr_ax_d;
            wr_dx     <= wr_dx_d;
            halted    <= halted_d;
            error     <= error_d;
            busy      <= busy_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        wide_d  = wide_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d   = instr_t'(rom_data);
                wide_d = dec_wide;
                if (dec_is_halt) begin
                    state_d = S_HALT;
                end else if (dec_illegal) begin
                    state_d = S_ERR;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = dec_needs_imm ? S_IMM : S_EXEC;
                end
            end
            S_IMM: begin
                imm_d   = rom_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT, S_ERR: begin
                if (run) begin
                    pc_d    = PC_RESET;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, registered above
    always_comb begin
        alu_start_d = 1'b0;
        wr_ax_d     = 1'b0;
        wr_dx_d     = 1'b0;
        halted_d    = 1'b0;
        error_d     = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            S_EXEC: alu_start_d = 1'b1;
            S_WB: begin
                wr_ax_d = wide_d || (ir_d.dst == REG_AX);
                wr_dx_d = wide_d || (ir_d.dst == REG_DX);
            end
            S_HALT: halted_d = 1'b1;
            S_ERR:  error_d  = 1'b1;
            default: ;
        endcase
        busy_d = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERR));
    end

    assign rom_addr = pc_q;
    assign alu_op   = ir_q.opcode;
    assign dst_sel  = ir_q.dst;
    assign src_sel  = ir_q.src;
    assign imm      = imm_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: ROM and ALU/register-file model,
// scoreboard of expected register writes, directed scenarios.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, run, run2;
    logic [7:0] rom_addr, rom_data, imm, rom_addr2, rom_data2, imm2;
    logic [3:0] alu_op, alu_op2;
    logic [1:0] dst_sel, src_sel, dst_sel2, src_sel2;
    logic       alu_start, alu_done, wr_ax, wr_dx, halted, error, busy;
    logic       alu_start2, alu_done2, wr_ax2, wr_dx2, halted2, error2, busy2;

    logic [7:0] rom  [256];
    logic [7:0] rom2 [256];
    assign rom_data  = rom[rom_addr];
    assign rom_data2 = rom2[rom_addr2];

    always #5 clk = ~clk;

    cpu_sequencer #(.ALU_TIMEOUT(64), .PC_RESET(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .alu_op(alu_op), .dst_sel(dst_sel), .src_sel(src_sel), .imm(imm),
        .alu_start(alu_start), .alu_done(alu_done), .wr_ax(wr_ax), .wr_dx(wr_dx),
        .halted(halted), .error(error), .busy(busy)
    );

    // Second instance starting at the top of the address space
    cpu_sequencer #(.ALU_TIMEOUT(64), .PC_RESET(8'd255)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .alu_op(alu_op2), .dst_sel(dst_sel2), .src_sel(src_sel2), .imm(imm2),
        .alu_start(alu_start2), .alu_done(alu_done2), .wr_ax(wr_ax2), .wr_dx(wr_dx2),
        .halted(halted2), .error(error2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nstarts, nwr, last_start, last_wr, nwr2;
    logic        alu_hang, start_prev, start_prev2;
    logic [7:0]  m_ax, m_dx;
    logic [15:0] res;
    logic [1:0]  wr2_seen;
    logic [17:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] wbv(input logic wa, input logic wd,
                                        input logic [7:0] ax, input logic [7:0] dx);
        return {wa, wd, ax, dx};
    endfunction

    function automatic logic [7:0] rd(input logic [1:0] sel);
        return (sel == 2'd0) ? imm : (sel == 2'd1) ? m_ax : m_dx;
    endfunction

    // One clock: sample at negedge, run the ALU model and scoreboard
    task automatic step();
        logic [7:0]  a, b;
        logic [15:0] q, r;
        @(negedge clk);
        cyc++;
        alu_done = !alu_hang && start_prev;
        start_prev = alu_start;
        if (alu_start) begin
            nstarts++;
            last_start = cyc;
            a = rd(dst_sel);
            b = rd(src_sel);
            case (alu_op)
                4'd0:  res = {8'h00, b};
                4'd1:  res = {8'h00, 8'(a + b)};
                4'd2:  res = {8'h00, 8'(a - b)};
                4'd4:  res = 16'(a * b);
                4'd5: begin
                    q = {m_dx, m_ax} / {8'h00, b};
                    r = {m_dx, m_ax} % {8'h00, b};
                    res = {r[7:0], q[7:0]};
                end
                4'd6:  res = {8'h00, a | b};
                4'd7:  res = {8'h00, ~a};
                4'd8:  res = {8'h00, a & b};
                4'd9:  res = {8'h00, a ^ b};
                4'd10: res = {8'h00, 8'(a << b)};
                4'd11: res = {8'h00, a >> b};
                default: res = 16'h0000;
            endcase
        end
        if (wr_ax || wr_dx) begin
            nwr++;
            last_wr = cyc;
            if (wr_ax && wr_dx) begin
                m_ax = res[7:0];
                m_dx = res[15:8];
            end else if (wr_ax) begin
                m_ax = res[7:0];
            end else begin
                m_dx = res[7:0];
            end
            chk("wb_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("wb_value", 32'(wbv(wr_ax, wr_dx, m_ax, m_dx)), 32'(sb.pop_front()));
        end
        alu_done2 = start_prev2;
        start_prev2 = alu_start2;
        if (wr_ax2 || wr_dx2) begin
            nwr2++;
            wr2_seen = {wr_ax2, wr_dx2};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        run2 = 1'b0;
        alu_hang = 1'b0;
        alu_done = 1'b0;
        alu_done2 = 1'b0;
        start_prev = 1'b0;
        start_prev2 = 1'b0;
        nstarts = 0; nwr = 0; nwr2 = 0; last_start = 0; last_wr = 0;
        wr2_seen = 2'b00;
        m_ax = 8'h00; m_dx = 8'h00; res = 16'h0000;
        sb.delete();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'h30;
            rom2[i] = 8'h30;
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        logic [7:0] demo [22];
        demo = '{8'h08, 8'd15, 8'h04, 8'd6, 8'h14, 8'd7, 8'h29, 8'h44, 8'd40, 8'h2A,
                 8'h54, 8'd5, 8'h04, 8'd11, 8'h78, 8'h86, 8'hB8, 8'd1, 8'hA4, 8'd1,
                 8'h09, 8'h30};

        // Reset state
        rst_n = 1'b0;
        do_reset();
        rst_n = 1'b0;
        step();
        chk("rst_status", 32'({busy, halted, error, alu_start, wr_ax, wr_dx}), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_ir_fields", 32'({alu_op, dst_sel, src_sel}), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);
        chk("rst_pc2", 32'(rom_addr2), 32'd255);
        rst_n = 1'b1;

        // 1: demo program
        do_reset();
        for (int i = 0; i < 22; i++) rom[i] = demo[i];
        sb.push_back(wbv(1'b0, 1'b1, 8'h00, 8'h0F));
        sb.push_back(wbv(1'b1, 1'b0, 8'h06, 8'h0F));
        sb.push_back(wbv(1'b1, 1'b0, 8'h0D, 8'h0F));
        sb.push_back(wbv(1'b0, 1'b1, 8'h0D, 8'h02));
        sb.push_back(wbv(1'b1, 1'b1, 8'h08, 8'h02));
        sb.push_back(wbv(1'b0, 1'b1, 8'h08, 8'h00));
        sb.push_back(wbv(1'b1, 1'b1, 8'h01, 8'h03));
        sb.push_back(wbv(1'b1, 1'b0, 8'h0B, 8'h03));
        sb.push_back(wbv(1'b0, 1'b1, 8'h0B, 8'hFC));
        sb.push_back(wbv(1'b1, 1'b0, 8'h08, 8'hFC));
        sb.push_back(wbv(1'b0, 1'b1, 8'h08, 8'h7E));
        sb.push_back(wbv(1'b1, 1'b0, 8'h10, 8'h7E));
        sb.push_back(wbv(1'b0, 1'b1, 8'h10, 8'h10));
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 400 && !halted; i++) step();
        chk("demo_halted", 32'(halted), 32'd1);
        chk("demo_halt_addr", 32'(rom_addr), 32'd21);
        chk("demo_sb_empty", 32'(sb.size()), 32'd0);
        chk("demo_no_error", 32'({error, busy}), 32'd0);

        // 2: illegal opcode at address 0
        do_reset();
        rom[0] = 8'hC0;
        run = 1'b1;
        k = 0;
        while (!error && k < 10) begin
            step();
            k++;
            if (k == 1) run = 1'b0;
        end
        chk("ill_error", 32'(error), 32'd1);
        chk("ill_latency", 32'(k), 32'd2);
        chk("ill_rom_addr", 32'(rom_addr), 32'd0);
        chk("ill_no_start", 32'(nstarts), 32'd0);
        chk("ill_not_busy", 32'(busy), 32'd0);

        // 3: ALU timeout, then restart from ERR
        do_reset();
        rom[0] = 8'h16;
        alu_hang = 1'b1;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 200 && !error; i++) step();
        chk("to_error", 32'(error), 32'd1);
        chk("to_latency", 32'(cyc - last_start), 32'd64);
        chk("to_no_write", 32'(nwr), 32'd0);
        chk("to_one_start", 32'(nstarts), 32'd1);
        run = 1'b1;
        step();
        run = 1'b0;
        chk("restart_err_clr", 32'({error, halted}), 32'd0);
        chk("restart_pc", 32'(rom_addr), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        // 4: NOT DX, no immediate
        do_reset();
        rom[0] = 8'h78;
        m_dx = 8'h03;
        sb.push_back(wbv(1'b0, 1'b1, 8'h00, 8'hFC));
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("not_exec_after_fetch", 32'(alu_start), 32'd1);
        chk("not_pc", 32'(rom_addr), 32'd1);
        for (int i = 0; i < 50 && !halted; i++) step();
        chk("not_start_to_wr", 32'(last_wr - last_start), 32'd2);
        chk("not_one_write", 32'(nwr), 32'd1);
        chk("not_sb_empty", 32'(sb.size()), 32'd0);
        chk("not_halt_addr", 32'({halted, rom_addr}), 32'h101);

        // 5: reset during WAIT of MUL
        do_reset();
        rom[0] = 8'h44;
        rom[1] = 8'd40;
        alu_hang = 1'b1;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 20 && nstarts == 0; i++) step();
        step();
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_status", 32'({busy, halted, error, alu_start, wr_ax, wr_dx}), 32'd0);
        chk("abort_rom_addr", 32'(rom_addr), 32'd0);
        chk("abort_fields", 32'({alu_op, dst_sel, src_sel, imm}), 32'd0);
        step();
        rst_n = 1'b1;
        alu_hang = 1'b0;
        start_prev = 1'b0;
        step();
        chk("abort_no_write", 32'(nwr), 32'd0);
        sb.push_back(wbv(1'b1, 1'b1, 8'h00, 8'h00));
        run = 1'b1;
        step();
        run = 1'b0;
        chk("rerun_fetch", 32'({busy, rom_addr}), 32'h100);
        step();
        step();
        chk("rerun_imm", 32'({alu_start, imm}), 32'h128);
        for (int i = 0; i < 30 && !halted; i++) step();
        chk("rerun_done", 32'({halted, 8'(sb.size())}), 32'h100);

        // 6: PC wrap with MOV AX,imm at 255
        do_reset();
        rom2[255] = 8'h04;
        rom2[0] = 8'h5A;
        run2 = 1'b1;
        step();
        run2 = 1'b0;
        chk("wrap_fetch_addr", 32'(rom_addr2), 32'd255);
        step();
        chk("wrap_pc0", 32'(rom_addr2), 32'd0);
        step();
        chk("wrap_exec", 32'({alu_start2, rom_addr2, imm2}), 32'h1015A);
        for (int i = 0; i < 20 && !halted2; i++) step();
        chk("wrap_write", 32'({8'(nwr2), wr2_seen}), 32'h6);
        chk("wrap_halt", 32'({halted2, rom_addr2}), 32'h101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
